// File: rtl/timer_unit.sv
// Dual memory-mapped down-counter timer with a shared prescaler.
// Each timer raises a one-cycle irq pulse when it expires with IE set.
module timer_unit #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [1:0]  int_ack,
  output logic [1:0]  irq
);

  logic tick;

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] pre_q, pre_d;

      always_comb begin
        tick  = (pre_q == PW'(PRESCALE - 1));
        pre_d = tick ? '0 : pre_q + PW'(1);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
      end
    end else begin : g_nopre
      assign tick = 1'b1;
    end
  endgenerate

  logic [2:0]       ctrl_rd  [2];
  logic [WIDTH-1:0] load_rd  [2];
  logic [WIDTH-1:0] count_rd [2];
  logic [1:0]       exp_rd;

  for (genvar gi = 0; gi < 2; gi++) begin : g_tmr
    logic [2:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             exp_q, exp_d;
    logic             irq_q, irq_d;
    logic             sel, load_wr, ctrl_wr, stat_clr, run, expire;

    always_comb begin
      sel      = we && (addr[2] == 1'(gi));
      load_wr  = sel && (addr[1:0] == 2'd1);
      ctrl_wr  = sel && (addr[1:0] == 2'd0);
      stat_clr = (sel && (addr[1:0] == 2'd3) && wdata[0]) || int_ack[gi];
      // A LOAD write pre-empts both decrement and expiry in the same cycle.
      run      = !load_wr && ctrl_q[0] && tick;
      expire   = run && (count_q == '0);

      ctrl_d  = ctrl_q;
      load_d  = load_q;
      count_d = count_q;
      exp_d   = exp_q;

      if (load_wr) begin
        load_d  = wdata[WIDTH-1:0];
        count_d = wdata[WIDTH-1:0];
      end else if (run && !expire) begin
        count_d = count_q - WIDTH'(1);
      end else if (expire) begin
        if (ctrl_q[1]) count_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end

      // Software CTRL write overrides the one-shot EN clear.
      if (ctrl_wr) ctrl_d = wdata[2:0];

      if (stat_clr) exp_d = 1'b0;
      if (expire)   exp_d = 1'b1;

      irq_d = expire && ctrl_q[2];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ctrl_q  <= '0;
        load_q  <= '0;
        count_q <= '0;
        exp_q   <= 1'b0;
        irq_q   <= 1'b0;
      end else begin
        ctrl_q  <= ctrl_d;
        load_q  <= load_d;
        count_q <= count_d;
        exp_q   <= exp_d;
        irq_q   <= irq_d;
      end
    end

    assign ctrl_rd[gi]  = ctrl_q;
    assign load_rd[gi]  = load_q;
    assign count_rd[gi] = count_q;
    assign exp_rd[gi]   = exp_q;
    assign irq[gi]      = irq_q;
  end

  always_comb begin
    rdata = '0;
    case (addr[1:0])
      2'd0:    rdata[2:0]       = ctrl_rd[addr[2]];
      2'd1:    rdata[WIDTH-1:0] = load_rd[addr[2]];
      2'd2:    rdata[WIDTH-1:0] = count_rd[addr[2]];
      default: rdata[0]         = exp_rd[addr[2]];
    endcase
  end

endmodule

// File: tb/tb_timer_unit.sv
// Bench for timer_unit: two instances (PRESCALE 1 and 4) share one bus and are
// compared every cycle against a rule-level reference model.
`timescale 1ns/1ps
module tb_timer_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  int_ack = '0;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  irq_a, irq_b;

  always #10 clk = ~clk;

  timer_unit #(.WIDTH(32), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .int_ack(int_ack), .irq(irq_a)
  );

  timer_unit #(.WIDTH(32), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .int_ack(int_ack), .irq(irq_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, indexed [instance][timer].
  int unsigned m_ps [2] = '{1, 4};
  int unsigned m_cyc [2];
  logic [2:0]  m_ctrl  [2][2];
  logic [31:0] m_load  [2][2];
  logic [31:0] m_count [2][2];
  logic        m_exp   [2][2];
  logic        m_irq   [2][2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cyc[d] = 0;
      for (int n = 0; n < 2; n++) begin
        m_ctrl[d][n]  = '0;
        m_load[d][n]  = '0;
        m_count[d][n] = '0;
        m_exp[d][n]   = 1'b0;
        m_irq[d][n]   = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] m_read(input int d, input logic [2:0] a);
    int n;
    n = a[2] ? 1 : 0;
    case (a[1:0])
      2'd0:    return {29'b0, m_ctrl[d][n]};
      2'd1:    return m_load[d][n];
      2'd2:    return m_count[d][n];
      default: return {31'b0, m_exp[d][n]};
    endcase
  endfunction

  task automatic model_edge(input logic w, input logic [2:0] a, input logic [31:0] wd,
                            input logic [1:0] ack);
    bit tick, mine, expired;
    logic [2:0] old_ctrl;
    for (int d = 0; d < 2; d++) begin
      tick = ((m_cyc[d] % m_ps[d]) == (m_ps[d] - 1));
      m_cyc[d]++;
      for (int n = 0; n < 2; n++) begin
        mine     = w && (int'(a[2]) == n);
        expired  = 1'b0;
        old_ctrl = m_ctrl[d][n];
        if (mine && a[1:0] == 2'd1) begin
          m_load[d][n]  = wd;
          m_count[d][n] = wd;
        end else if (old_ctrl[0] && tick) begin
          if (m_count[d][n] != 0) begin
            m_count[d][n] = m_count[d][n] - 1;
          end else begin
            expired = 1'b1;
            if (old_ctrl[1]) m_count[d][n] = m_load[d][n];
            else             m_ctrl[d][n][0] = 1'b0;
          end
        end
        if (mine && a[1:0] == 2'd0) m_ctrl[d][n] = wd[2:0];
        if ((mine && a[1:0] == 2'd3 && wd[0]) || ack[n]) m_exp[d][n] = 1'b0;
        if (expired) m_exp[d][n] = 1'b1;
        m_irq[d][n] = expired && old_ctrl[2];
      end
    end
  endtask

  task automatic step(input string tag, input logic w, input logic [2:0] a,
                      input logic [31:0] wd, input logic [1:0] ack);
    we = w; addr = a; wdata = wd; int_ack = ack;
    #1;
    check({tag, "/rdata_a"}, rdata_a, m_read(0, a));
    check({tag, "/rdata_b"}, rdata_b, m_read(1, a));
    check({tag, "/irq_a"}, {30'b0, irq_a}, {30'b0, m_irq[0][1], m_irq[0][0]});
    check({tag, "/irq_b"}, {30'b0, irq_b}, {30'b0, m_irq[1][1], m_irq[1][0]});
    @(posedge clk);
    model_edge(w, a, wd, ack);
    #1;
    we = 1'b0; int_ack = '0;
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rwd;
    logic [1:0]  rack;
    logic        rw;
    int          r;

    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    for (int a = 0; a < 8; a++) step("reset_state", 1'b0, 3'(a), 32'h0, 2'b00);

    // T1: periodic reload on timer0.
    step("t1_load", 1'b1, 3'b001, 32'd3, 2'b00);
    step("t1_ctrl", 1'b1, 3'b000, 32'd7, 2'b00);
    repeat (12) step("t1_count", 1'b0, 3'b010, 32'h0, 2'b00);

    // T2: one-shot on timer1.
    step("t2_load", 1'b1, 3'b101, 32'd2, 2'b00);
    step("t2_ctrl", 1'b1, 3'b100, 32'd5, 2'b00);
    repeat (6) step("t2_count", 1'b0, 3'b110, 32'h0, 2'b00);
    step("t2_ctrl_rd", 1'b0, 3'b100, 32'h0, 2'b00);
    step("t2_stat_rd", 1'b0, 3'b111, 32'h0, 2'b00);

    // T3: W1C landing on the expiry edge of timer0 in the PRESCALE=1 instance.
    for (int k = 0; k < 12 && !(m_ctrl[0][0][0] && m_count[0][0] == 0); k++)
      step("t3_wait", 1'b0, 3'b010, 32'h0, 2'b00);
    step("t3_w1c", 1'b1, 3'b011, 32'h1, 2'b00);
    step("t3_exp", 1'b0, 3'b011, 32'h0, 2'b00);

    // T4: ack only timer0.
    step("t4_ack", 1'b0, 3'b011, 32'h0, 2'b01);
    step("t4_st0", 1'b0, 3'b011, 32'h0, 2'b00);
    step("t4_st1", 1'b0, 3'b111, 32'h0, 2'b00);
    step("t4_cnt0", 1'b0, 3'b010, 32'h0, 2'b00);
    step("t4_cnt1", 1'b0, 3'b110, 32'h0, 2'b00);

    // T5: short reload period, then a LOAD write mid-count.
    step("t5_load", 1'b1, 3'b001, 32'd1, 2'b00);
    repeat (24) step("t5_run", 1'b0, 3'b010, 32'h0, 2'b00);
    step("t5_reload", 1'b1, 3'b001, 32'd5, 2'b00);
    repeat (30) step("t5_run2", 1'b0, 3'b010, 32'h0, 2'b00);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      r   = $urandom_range(0, 99);
      ra  = 3'($urandom_range(0, 7));
      rw  = 1'b0;
      rwd = $urandom;
      if (r < 8) begin
        rw = 1'b1; ra[1:0] = 2'd1;
        rwd = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 6));
      end else if (r < 14) begin
        rw = 1'b1; ra[1:0] = 2'd0;
        rwd = 32'($urandom_range(0, 7)) | ($urandom & 32'hffff_fff8);
      end else if (r < 18) begin
        rw = 1'b1; ra[1:0] = 2'd3;
      end else if (r < 20) begin
        rw = 1'b1; ra[1:0] = 2'd2;
      end
      rack = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step("rand", rw, ra, rwd, rack);
    end

    // T6: asynchronous reset mid-count.
    step("t6_ld0", 1'b1, 3'b001, 32'd3, 2'b00);
    step("t6_c0", 1'b1, 3'b000, 32'd7, 2'b00);
    step("t6_ld1", 1'b1, 3'b101, 32'd2, 2'b00);
    step("t6_c1", 1'b1, 3'b100, 32'd7, 2'b00);
    repeat (5) step("t6_run", 1'b0, 3'b010, 32'h0, 2'b00);
    #1 reset = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      check("t6_async_rd_a", rdata_a, 32'h0);
      check("t6_async_rd_b", rdata_b, 32'h0);
      check("t6_async_irq", {28'b0, irq_b, irq_a}, 32'h0);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    for (int a = 0; a < 8; a++) step("t6_post", 1'b0, 3'(a), 32'h0, 2'b00);
    repeat (20) step("t6_idle", 1'b0, 3'b010, 32'h0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
